// File: rtl/int_to_ieee754.sv
// ---------------------------------------------------------------------------
// int_to_ieee754
//
// Converts a signed 32-bit two's-complement integer into an IEEE 754 single
// precision value, rounding to nearest even. One conversion is in flight at a
// time. The magnitude is normalised by shifting left one bit per clock, so the
// latency is the leading-zero count plus one (zero input completes at once).
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   in_valid     in_data holds an integer to convert
//   in_ready     converter can accept a new integer (IDLE only)
//   in_data      signed 32-bit integer
//   out_valid    out_data / out_inexact hold a completed result
//   out_ready    downstream accepts the result
//   out_data     {sign, exp[7:0], frac[22:0]}
//   out_inexact  result was rounded (guard or sticky bit nonzero)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for in_valid; in_ready high
// NORM  | shifting mag left until bit 31 is set, then round
// DONE  | result presented with out_valid; held until out_ready
// ---------------------------------------------------------------------------
module int_to_ieee754 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_inexact
);

    // Exponent of a magnitude whose leading one sits in bit 31 (127 + 31).
    localparam logic [7:0] EXP_TOP = 8'd158;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        sign;
    logic [31:0] mag;
    logic [7:0]  exp;

    logic [31:0] in_mag;
    logic        in_zero;

    logic [22:0] frac;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] frac_sum;
    logic [22:0] frac_rnd;
    logic [7:0]  exp_rnd;

    // Absolute value of the incoming integer. -2^31 negates to itself, which
    // read as unsigned is exactly the 0x80000000 magnitude we want.
    always_comb begin
        in_mag  = in_data[31] ? (~in_data + 32'd1) : in_data;
        in_zero = (in_mag == 32'd0);
    end

    // Round-to-nearest-even on the normalised magnitude. The hidden one is
    // mag[31]; a carry out of the 23-bit fraction means the significand
    // became 2.0, so the fraction wraps to zero and the exponent steps up.
    always_comb begin
        frac     = mag[30:8];
        guard    = mag[7];
        sticky   = |mag[6:0];
        round_up = guard & (sticky | frac[0]);
        frac_sum = {1'b0, frac} + {23'd0, round_up};
        frac_rnd = frac_sum[22:0];
        exp_rnd  = exp + {7'd0, frac_sum[23]};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = in_zero ? DONE : NORM;
                end
            end
            NORM: begin
                if (mag[31]) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs, decoded from state only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Datapath. The result registers are written only on the edge that
    // enters DONE, so they stay stable for as long as downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign        <= 1'b0;
            mag         <= 32'd0;
            exp         <= 8'd0;
            out_data    <= 32'd0;
            out_inexact <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign <= in_data[31];
                        mag  <= in_mag;
                        exp  <= EXP_TOP;
                        // Zero skips normalisation; +0 is produced even for
                        // the (impossible) negative zero, never -0.
                        if (in_zero) begin
                            out_data    <= 32'd0;
                            out_inexact <= 1'b0;
                        end
                    end
                end
                NORM: begin
                    if (!mag[31]) begin
                        mag <= {mag[30:0], 1'b0};
                        exp <= exp - 8'd1;
                    end else begin
                        out_data    <= {sign, exp_rnd, frac_rnd};
                        out_inexact <= guard | sticky;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/int_to_ieee754.md
# int_to_ieee754

Multi-cycle converter from signed 32-bit two's-complement integer to IEEE 754 single precision, rounding to nearest even. It produces the float operands consumed by the floating-point adder, making it the encode side of the same 32-bit float format. One conversion is in flight at a time. Input and output each use a valid/ready handshake.

## Interface
- No parameters; widths fixed at 32-bit integer in, 32-bit IEEE 754 single out.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds an integer to convert.
- in_ready  output  1  block can accept; high only in IDLE.
- in_data  input  32  signed two's-complement integer.
- out_valid  output  1  out_data/out_inexact hold a completed result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  32  {sign, exp[7:0], frac[22:0]}.
- out_inexact  output  1  result was rounded (guard or sticky nonzero).

## Operation
- States: IDLE, NORM, DONE.
- IDLE: in_ready=1. On an edge with in_valid=1:
  - sign ← in_data[31].
  - mag ← sign ? −in_data : in_data, as 32-bit unsigned; −2^31 gives 0x80000000.
  - exp ← 158 (127+31).
  - If mag==0: out_data ← 0x00000000, out_inexact ← 0, go to DONE. Otherwise go to NORM.
- NORM: in_ready=0.
  - If mag[31]==0: mag ← mag<<1, exp ← exp−1, stay in NORM.
  - If mag[31]==1: round and go to DONE.
- Rounding, performed in the NORM→DONE edge:
  - frac=mag[30:8], guard=mag[7], sticky=|mag[6:0].
  - Increment frac if guard & (sticky | frac[0]).
  - If the increment overflows (frac was 0x7FFFFF): frac ← 0, exp ← exp+1.
  - out_data ← {sign, exp, frac}; out_inexact ← guard|sticky.
- DONE: out_valid=1, in_ready=0.
  - out_data and out_inexact are held stable while out_ready=0.
  - On an edge with out_ready=1, go to IDLE.
- Number formats:
  - Result exponent range is 127..158. No NaN, Inf or denormal results are possible.
  - −0 is never produced.
- rst (any time, including mid-NORM or mid-DONE):
  - Go to IDLE immediately and discard any in-flight conversion.
  - in_ready=1 while rst is high and after its release.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0x00000000, out_inexact=0.
- Let acceptance happen at edge k (in_valid & in_ready). Let lz be the leading-zero count of the nonzero mag, 0..31.
  - Zero input: out_valid=1 from edge k.
  - Nonzero input: out_valid=1 from edge k+lz+1.
- Worst case is input ±1: 32 edges.
- Throughput: the next acceptance occurs no earlier than the edge after the one on which out_valid & out_ready.
- in_valid seen while in_ready=0 is ignored. The upstream source must hold it.
- out_valid falls on the edge where out_ready=1 is sampled. in_ready rises on that same edge.
- out_ready is sampled only in DONE. It has no effect in IDLE or NORM.

## Test plan
- Reset asserted mid-NORM (input 1, at edge k+5):
  - Outputs go to reset values asynchronously.
  - A new input 5 then yields 0x40A00000 with out_inexact=0.
- Exact conversions, out_inexact=0:
  - 1 → 0x3F800000 at edge k+32.
  - −1 → 0xBF800000.
  - 0 → 0x00000000 at edge k.
  - −2147483648 → 0xCF000000 at edge k+1.
- Rounding:
  - 16777217 → 0x4B800000, inexact=1 (tie to even).
  - 16777219 → 0x4B800002, inexact=1 (tie rounds up).
  - 2147483647 → 0x4F000000, inexact=1 (mantissa overflow bumps exponent).
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid.
  - out_data stays constant and in_ready stays 0, even with in_valid high.
  - The result is released on the first out_ready=1 edge.
- Back-to-back with out_ready tied 1 and in_valid tied 1 (inputs 3 then −7):
  - Results are 0x40400000 then 0xC0E00000.
  - No input is lost or duplicated.
- Random regression: compare 10k random integers against a reference round-to-nearest-even conversion, checking data, inexact flag and latency lz+1.
